// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control unit for the Mini-SRC datapath: sequences fetch (T0-T2)
// and execute (T3-T6) for ALU, unary, multiply/divide, nop and halt instructions.
module mini_src_control_unit #(
    parameter int unsigned OPC_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             start,
    output logic             PCout,
    output logic             IncPC,
    output logic             PCin,
    output logic             MARin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [OPC_W-1:0] alu_op,
    output logic             run,
    output logic             illegal_op
);

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu3, ClsUnary, ClsMulDiv, ClsNop, ClsHalt, ClsIllegal
    } cls_e;

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q;
    logic             start_q;
    cls_e             cls;

    // State, latched opcode and previous start level for edge detection.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StReset;
            opc_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            // IR becomes valid after T2, so this is the only edge the opcode is taken.
            if (state_q == StT2) begin
                opc_q <= opcode;
            end
        end
    end

    // Classify the latched opcode.
    always_comb begin
        cls = ClsIllegal;
        case (opc_q)
            OPC_W'(5'b00011), OPC_W'(5'b00100), OPC_W'(5'b00101),
            OPC_W'(5'b00110), OPC_W'(5'b00111), OPC_W'(5'b01001): cls = ClsAlu3;
            OPC_W'(5'b10001), OPC_W'(5'b10010):                   cls = ClsUnary;
            OPC_W'(5'b01111), OPC_W'(5'b10000):                   cls = ClsMulDiv;
            OPC_W'(5'b11010):                                     cls = ClsNop;
            OPC_W'(5'b11011):                                     cls = ClsHalt;
            default:                                              cls = ClsIllegal;
        endcase
    end

    assign run = (state_q != StReset) && (state_q != StHalt);

    // Next-state and control outputs; everything defaults to inactive.
    always_comb begin
        state_d    = state_q;
        PCout      = 1'b0;
        IncPC      = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        alu_op     = '0;
        illegal_op = 1'b0;
        unique case (state_q)
            StReset: state_d = StT0;
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // PC loads only on the exiting cycle so wait states cannot re-increment it.
                if (mem_ready) begin
                    PCin    = 1'b1;
                    state_d = StT2;
                end
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                case (cls)
                    ClsAlu3: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        state_d = StT4;
                    end
                    ClsUnary: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opc_q;
                        state_d = StT4;
                    end
                    ClsMulDiv: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        state_d = StT4;
                    end
                    ClsNop:  state_d = StT0;
                    ClsHalt: state_d = StHalt;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StT0;
                    end
                endcase
            end
            StT4: begin
                state_d = StT0;
                case (cls)
                    ClsAlu3: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opc_q;
                        state_d = StT5;
                    end
                    ClsUnary: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    ClsMulDiv: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opc_q;
                        state_d = StT5;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                state_d = StT0;
                case (cls)
                    ClsAlu3: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    ClsMulDiv: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                        state_d = StT6;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = StT0;
            end
            StHalt: begin
                // Rising edge only, so a held start restarts once.
                if (start && !start_q) begin
                    state_d = StT0;
                end
            end
            default: state_d = StReset;
        endcase
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed bench for mini_src_control_unit: table of instructions with expected cycle
// counts and enable tallies, plus hand-written reset, halt/start and mul walk sequences.
module tb_mini_src_control_unit;

    logic       clock = 1'b0;
    logic       clear;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       start;
    logic PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [4:0] alu_op;
    logic run, illegal_op;

    mini_src_control_unit #(.OPC_W(5)) dut (
        .clock(clock), .clear(clear), .opcode(opcode), .mem_ready(mem_ready), .start(start),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .alu_op(alu_op), .run(run),
        .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    // Packed view of all 1-bit outputs, MSB first.
    logic [20:0] vec;
    assign vec = {PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Gra, Grb, Grc,
                  Rin, Rout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, run, illegal_op};

    localparam logic [20:0] BPcOut = 21'h1 << 20, BIncPc = 21'h1 << 19, BPcIn = 21'h1 << 18;
    localparam logic [20:0] BMarIn = 21'h1 << 17, BRead = 21'h1 << 16, BMdrIn = 21'h1 << 15;
    localparam logic [20:0] BMdrOut = 21'h1 << 14, BIrIn = 21'h1 << 13, BGra = 21'h1 << 12;
    localparam logic [20:0] BGrb = 21'h1 << 11, BGrc = 21'h1 << 10, BRin = 21'h1 << 9;
    localparam logic [20:0] BRout = 21'h1 << 8, BYin = 21'h1 << 7, BZin = 21'h1 << 6;
    localparam logic [20:0] BZlo = 21'h1 << 5, BZhi = 21'h1 << 4, BHiIn = 21'h1 << 3;
    localparam logic [20:0] BLoIn = 21'h1 << 2, BRun = 21'h1 << 1;
    localparam logic [20:0] VecT0 = BPcOut | BIncPc | BMarIn | BZin | BRun;

    localparam logic [4:0] OpHalt = 5'b11011;
    localparam logic [4:0] OpMul  = 5'b01111;

    int n_tests = 0;
    int n_fail  = 0;

    int r_cycles, r_pcin, r_rin, r_hi, r_lo, r_ill, r_alu_ok, r_alu_bad, r_excl_bad;
    logic r_halted;

    typedef struct {
        logic [4:0] opc;
        int         waits;
        int         cyc;
        int         rin;
        int         hi;
        int         lo;
        int         ill;
        int         alu;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tally(input logic [4:0] opc);
        r_cycles++;
        r_pcin += int'(PCin);
        r_rin  += int'(Rin);
        r_hi   += int'(HIin);
        r_lo   += int'(LOin);
        r_ill  += int'(illegal_op);
        if (alu_op != 5'd0) begin
            if (alu_op == opc) r_alu_ok++;
            else r_alu_bad++;
        end
        if ($countones({PCout, MDRout, Rout, Zlowout, Zhighout}) > 1) r_excl_bad++;
    endtask

    task automatic stop_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for next T0 or HALT", name);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench stopped on timeout");
    endtask

    // Entered with the DUT observed in T0; returns at the next observed T0 or HALT.
    task automatic run_instr(input logic [4:0] opc, input int waits, input logic st);
        int left;
        left = waits;
        r_cycles = 0; r_pcin = 0; r_rin = 0; r_hi = 0; r_lo = 0; r_ill = 0;
        r_alu_ok = 0; r_alu_bad = 0; r_excl_bad = 0; r_halted = 1'b0;
        start = st;
        tally(opc);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            mem_ready = !(Read && left > 0);
            if (Read && left > 0) left--;
            // Present the real opcode only while IR loads; a halt code elsewhere must be ignored.
            opcode = IRin ? opc : OpHalt;
            #1;
            if (PCout || !run) begin
                r_halted = !run;
                return;
            end
            tally(opc);
        end
        stop_timeout("run_instr");
    endtask

    task automatic step(input logic [4:0] opc);
        @(negedge clock);
        mem_ready = 1'b1;
        opcode = IRin ? opc : OpHalt;
        #1;
    endtask

    initial begin
        #200000;
        stop_timeout("global");
    end

    initial begin
        logic [20:0] mulv[7];
        int bad;

        tbl[0]  = '{5'b00011, 0, 6, 1, 0, 0, 0, 1};  // add
        tbl[1]  = '{5'b00011, 3, 9, 1, 0, 0, 0, 1};  // add, 3 wait cycles
        tbl[2]  = '{5'b00100, 0, 6, 1, 0, 0, 0, 1};  // sub
        tbl[3]  = '{5'b00101, 1, 7, 1, 0, 0, 0, 1};  // and
        tbl[4]  = '{5'b00110, 0, 6, 1, 0, 0, 0, 1};  // or
        tbl[5]  = '{5'b00111, 0, 6, 1, 0, 0, 0, 1};  // shr
        tbl[6]  = '{5'b01001, 2, 8, 1, 0, 0, 0, 1};  // shl
        tbl[7]  = '{5'b10001, 0, 5, 1, 0, 0, 0, 1};  // neg
        tbl[8]  = '{5'b10010, 1, 6, 1, 0, 0, 0, 1};  // not
        tbl[9]  = '{5'b01111, 0, 7, 0, 1, 1, 0, 1};  // mul
        tbl[10] = '{5'b10000, 2, 9, 0, 1, 1, 0, 1};  // div
        tbl[11] = '{5'b11010, 0, 4, 0, 0, 0, 0, 0};  // nop
        tbl[12] = '{5'b11111, 0, 4, 0, 0, 0, 1, 0};  // illegal
        tbl[13] = '{5'b00000, 1, 5, 0, 0, 0, 1, 0};  // illegal
        tbl[14] = '{5'b01000, 0, 4, 0, 0, 0, 1, 0};  // illegal

        mulv[0] = VecT0;
        mulv[1] = BZlo | BPcIn | BRead | BMdrIn | BRun;
        mulv[2] = BMdrOut | BIrIn | BRun;
        mulv[3] = BGra | BRout | BYin | BRun;
        mulv[4] = BGrb | BRout | BZin | BRun;
        mulv[5] = BZlo | BLoIn | BRun;
        mulv[6] = BZhi | BHiIn | BRun;

        clear = 1'b0; start = 1'b0; mem_ready = 1'b1; opcode = 5'd0;
        #3;
        check_vec("reset outputs", vec, 21'd0);
        check("reset alu_op", int'(alu_op), 0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_vec("reset held before edge", vec, 21'd0);
        @(negedge clock);
        #1;
        check_vec("first T0 after reset", vec, VecT0);

        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i].opc, tbl[i].waits, 1'b0);
            check($sformatf("cycles[%0d]", i), r_cycles, tbl[i].cyc);
            check($sformatf("pcin[%0d]", i), r_pcin, 1);
            check($sformatf("rin[%0d]", i), r_rin, tbl[i].rin);
            check($sformatf("hiin[%0d]", i), r_hi, tbl[i].hi);
            check($sformatf("loin[%0d]", i), r_lo, tbl[i].lo);
            check($sformatf("illegal[%0d]", i), r_ill, tbl[i].ill);
            check($sformatf("alu_op[%0d]", i), r_alu_ok, tbl[i].alu);
            check($sformatf("alu_op_wrong[%0d]", i), r_alu_bad, 0);
            check($sformatf("bus_excl[%0d]", i), r_excl_bad, 0);
            check($sformatf("halted[%0d]", i), int'(r_halted), 0);
        end

        // Cycle-by-cycle mul r4,r5.
        for (int k = 0; k < 7; k++) begin
            check_vec($sformatf("mul vec T%0d", k), vec, mulv[k]);
            check($sformatf("mul alu_op T%0d", k), int'(alu_op), (k == 4) ? int'(OpMul) : 0);
            step(OpMul);
        end
        check_vec("mul back to T0", vec, VecT0);

        // clear mid-T4 of mul.
        for (int k = 0; k < 4; k++) step(OpMul);
        check("mul T4 before clear", int'(Zin && alu_op == OpMul), 1);
        clear = 1'b0;
        #1;
        check_vec("clear mid-T4 same cycle", vec, 21'd0);
        check("clear mid-T4 alu_op", int'(alu_op), 0);
        @(negedge clock);
        #1;
        check_vec("clear held across edge", vec, 21'd0);
        clear = 1'b1;
        @(negedge clock);
        #1;
        check_vec("T0 after clear release", vec, VecT0);

        // halt, then 10 idle cycles, then a start pulse.
        run_instr(OpHalt, 0, 1'b0);
        check("halt entry cycles", r_cycles, 4);
        check("halt entered", int'(r_halted), 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            #1;
            if (vec !== 21'd0 || alu_op !== 5'd0) bad++;
        end
        check("halt quiet 10 cycles", bad, 0);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        check_vec("start leaves halt", vec, VecT0);

        // start during an ALU instruction changes nothing.
        run_instr(5'b00011, 0, 1'b1);
        check("add with start high cycles", r_cycles, 6);
        check("add with start high not halted", int'(r_halted), 0);
        check("add with start high rin", r_rin, 1);

        // start already held high on re-entering HALT gives no extra restart.
        run_instr(OpHalt, 0, 1'b1);
        check("halt again entered", int'(r_halted), 1);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            #1;
            if (run !== 1'b0) bad++;
        end
        check("held start no restart", bad, 0);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        check_vec("restart after new start edge", vec, VecT0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
